// File: rtl/dmem_access_unit_if.sv
// Single-outstanding req/ack data-memory bus.
// The access unit is the master; the memory model or fabric is the slave.
interface dmem_access_unit_if;
  logic        bus_req_out;
  logic        bus_we_out;
  logic [31:0] bus_addr_out;
  logic [3:0]  bus_wmask_out;
  logic [31:0] bus_wdata_out;
  logic        bus_ack_in;
  logic [31:0] bus_rdata_in;

  modport master (
    output bus_req_out,
    output bus_we_out,
    output bus_addr_out,
    output bus_wmask_out,
    output bus_wdata_out,
    input  bus_ack_in,
    input  bus_rdata_in
  );

  modport slave (
    input  bus_req_out,
    input  bus_we_out,
    input  bus_addr_out,
    input  bus_wmask_out,
    input  bus_wdata_out,
    output bus_ack_in,
    output bus_rdata_in
  );
endinterface

// File: rtl/dmem_access_unit.sv
// Data-memory access controller: latches a load/store, runs one req/ack bus transaction
// with timeout, and registers the read word for load alignment. Optional macro: MISALIGN_TRAP_EN.
module dmem_access_unit #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 mem_req_in,
  input  logic                 mem_wr_in,
  input  logic [1:0]           size_in,
  input  logic [31:0]          iadder_in,
  input  logic [31:0]          rs2_in,
  dmem_access_unit_if.master   bus,
  output logic [31:0]          dm_data_out,
  output logic [1:0]           iadder_out_1_to_0_out,
  output logic                 stall_out,
  output logic                 done_out,
  output logic                 bus_err_out
`ifdef MISALIGN_TRAP_EN
  ,
  output logic                 misaligned_out
`endif
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [3:0]    req_mask;
  logic [31:0]   req_wdata;

  // Stores replicate the significant bits onto every lane so the mask alone selects bytes.
  always_comb begin
    req_mask  = 4'b0000;
    req_wdata = 32'h0000_0000;
    if (mem_wr_in) begin
      case (size_in)
        2'b00: begin
          req_mask  = 4'b0001 << iadder_in[1:0];
          req_wdata = {4{rs2_in[7:0]}};
        end
        2'b01: begin
          req_mask  = iadder_in[1] ? 4'b1100 : 4'b0011;
          req_wdata = {2{rs2_in[15:0]}};
        end
        default: begin
          req_mask  = 4'b1111;
          req_wdata = rs2_in;
        end
      endcase
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic misaligned_req;

  always_comb begin
    misaligned_req = 1'b0;
    case (size_in)
      2'b00:   misaligned_req = 1'b0;
      2'b01:   misaligned_req = iadder_in[0];
      default: misaligned_req = |iadder_in[1:0];
    endcase
  end
`endif

  // Reset forces stall low even while the pipeline still presents a request.
  assign stall_out = !rst_in && (((state == IDLE) && mem_req_in) || (state == REQ));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state                 <= IDLE;
      timer                 <= '0;
      bus.bus_req_out       <= 1'b0;
      bus.bus_we_out        <= 1'b0;
      bus.bus_addr_out      <= 32'h0000_0000;
      bus.bus_wmask_out     <= 4'b0000;
      bus.bus_wdata_out     <= 32'h0000_0000;
      dm_data_out           <= 32'h0000_0000;
      iadder_out_1_to_0_out <= 2'b00;
      done_out              <= 1'b0;
      bus_err_out           <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misaligned_out        <= 1'b0;
`endif
    end else begin
      done_out    <= 1'b0;
      bus_err_out <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misaligned_out <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (mem_req_in) begin
            bus.bus_we_out        <= mem_wr_in;
            bus.bus_addr_out      <= {iadder_in[31:2], 2'b00};
            bus.bus_wmask_out     <= req_mask;
            bus.bus_wdata_out     <= req_wdata;
            iadder_out_1_to_0_out <= iadder_in[1:0];
            timer                 <= '0;
`ifdef MISALIGN_TRAP_EN
            if (misaligned_req) begin
              state          <= DONE;
              done_out       <= 1'b1;
              misaligned_out <= 1'b1;
            end else begin
              state           <= REQ;
              bus.bus_req_out <= 1'b1;
            end
`else
            state           <= REQ;
            bus.bus_req_out <= 1'b1;
`endif
          end
        end

        // An ack in the limit cycle takes priority over the timeout.
        REQ: begin
          if (bus.bus_ack_in) begin
            state           <= DONE;
            bus.bus_req_out <= 1'b0;
            done_out        <= 1'b1;
            if (!bus.bus_we_out) begin
              dm_data_out <= bus.bus_rdata_in;
            end
          end else if (timer == TIMER_LAST) begin
            state           <= DONE;
            bus.bus_req_out <= 1'b0;
            done_out        <= 1'b1;
            bus_err_out     <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state           <= IDLE;
          bus.bus_req_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
